// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction memory handshake plus decoder-side presentation bus.
interface instruction_fetch_unit_if #(parameter int ADDR_W = 32);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              stall;
    logic              branch_taken;
    logic [23:0]       br_address;
    logic [31:0]       instruction_set;
    logic              enable;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] link_addr;
    modport master (
        output imem_req, imem_addr, instruction_set, enable, pc_out, link_addr,
        input  imem_ack, imem_rdata, stall, branch_taken, br_address
    );
    modport slave (
        input  imem_req, imem_addr, instruction_set, enable, pc_out, link_addr,
        output imem_ack, imem_rdata, stall, branch_taken, br_address
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches over req/ack and presents one instruction at a time.
module instruction_fetch_unit #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                     clk,
    input logic                     reset_n,
    instruction_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
    state_t            state;
    logic [ADDR_W-1:0] pc, addr, pc_out_q, sk_pc, target;
    logic [31:0]       ins_q, sk_ins;
    logic              en_q, discard, consume, br, accept;
    assign consume = en_q && !bus.stall;
    assign br      = consume && bus.branch_taken;
    assign accept  = !en_q || consume;
    assign target  = pc_out_q + ADDR_W'(32'd8) + {{(ADDR_W-26){bus.br_address[23]}}, bus.br_address, 2'b00};
    assign bus.imem_req        = state == S_REQ;
    assign bus.imem_addr       = addr;
    assign bus.instruction_set = ins_q;
    assign bus.enable          = en_q;
    assign bus.pc_out          = pc_out_q;
    assign bus.link_addr       = pc_out_q + ADDR_W'(32'd4);
    // An ack landing while the presented word is stalled parks in the sk_* slot; S_HOLD means that slot is full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            addr     <= RESET_PC;
            discard  <= 1'b0;
            en_q     <= 1'b0;
            ins_q    <= '0;
            pc_out_q <= '0;
            sk_ins   <= '0;
            sk_pc    <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (br) begin
                        pc      <= target;
                        en_q    <= 1'b0;
                        discard <= !bus.imem_ack;
                        if (bus.imem_ack) addr <= target;
                    end else if (bus.imem_ack && discard) begin
                        discard <= 1'b0;
                        addr    <= pc;
                    end else if (bus.imem_ack) begin
                        pc   <= pc + ADDR_W'(32'd4);
                        addr <= pc + ADDR_W'(32'd4);
                        if (accept) begin
                            ins_q    <= bus.imem_rdata;
                            pc_out_q <= addr;
                            en_q     <= 1'b1;
                        end else begin
                            sk_ins <= bus.imem_rdata;
                            sk_pc  <= addr;
                            state  <= S_HOLD;
                        end
                    end else if (consume) begin
                        en_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (br) begin
                        pc    <= target;
                        addr  <= target;
                        en_q  <= 1'b0;
                        state <= S_REQ;
                    end else if (consume) begin
                        ins_q    <= sk_ins;
                        pc_out_q <= sk_pc;
                        state    <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
